fifo_packet_arbiter: RTL and testbench

FIFO_PACKET_ARBITER -- requirements
Module: fifo_packet_arbiter

---
 rtl/fifo_packet_arbiter_pkg.sv | 25 ++
 rtl/fifo_packet_arbiter_rr.sv | 38 +++
 rtl/fifo_packet_arbiter.sv | 175 +++++++++++++++++
 tb/tb_fifo_packet_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : fifo_packet_arbiter_package
// Brief   : Shared arbiter FSM state encoding and word-format helpers.
// Rev     : 1.0  initial release
// ============================================================================
package fifo_packet_arbiter_package;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // The end-of-packet flag sits this many bits below the word MSB
    localparam int unsigned LAST_FLAG_FROM_MSB = 0;

    // Bit position of the end-of-packet flag for a given word width
    function automatic int unsigned last_flag_pos(input int unsigned data_width);
        return data_width - 1 - LAST_FLAG_FROM_MSB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_packet_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : round_robin_priority_encoder
// Brief  : Finds the first set request bit searching upward from
//          previous_grant+1 with wrap-around; the previous grant itself is
//          checked last so a lone requester is re-granted.
// Rev    : 1.0  initial release
// ============================================================================
module round_robin_priority_encoder #(
    parameter int PORT_COUNT  = 4,
    parameter int GRANT_WIDTH = 2
) (
    input  logic [PORT_COUNT-1:0]  request,
    input  logic [GRANT_WIDTH-1:0] previous_grant,
    output logic [GRANT_WIDTH-1:0] next_grant,
    output logic                   found
);

    // Rotating first-match search over all ports
    always_comb begin
        int                   idx;
        logic [GRANT_WIDTH-1:0] w_idx;
        next_grant = previous_grant;
        found      = 1'b0;
        idx        = 0;
        w_idx      = '0;
        for (int i = 1; i <= PORT_COUNT; i++) begin
            idx   = (int'(previous_grant) + i) % PORT_COUNT;
            w_idx = GRANT_WIDTH'(idx);
            if (!found && request[w_idx]) begin
                found      = 1'b1;
                next_grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_packet_arbiter
// Brief  : Packet-granular round-robin arbiter draining PORT_COUNT ingress
//          FIFOs into one registered egress stream. One read is outstanding
//          at a time, so any FIFO read latency is tolerated.
// Config : FIFO_PACKET_ARBITER_WATCHDOG_EN enables the read-response
//          watchdog (WATCHDOG_CYCLES); otherwise watchdog_error is tied low.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_packet_arbiter
    import fifo_packet_arbiter_package::*;
#(
    parameter  int PORT_COUNT      = 4,
    parameter  int DATA_WIDTH      = 16,
    parameter  int WATCHDOG_CYCLES = 64,
    localparam int GRANT_WIDTH     = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [PORT_COUNT-1:0]            fifo_empty,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] fifo_read_data,
    input  logic [PORT_COUNT-1:0]            fifo_read_data_valid,
    output logic [PORT_COUNT-1:0]            fifo_read_enable,
    output logic [DATA_WIDTH-1:0]            output_data,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [GRANT_WIDTH-1:0]           grant_port,
    output logic                             busy,
    output logic                             watchdog_error
);

    localparam int LAST_BIT = int'(last_flag_pos(DATA_WIDTH));

    // Reject configurations the datapath cannot represent
    if (PORT_COUNT < 2 || DATA_WIDTH < 2 || WATCHDOG_CYCLES < 2) begin : g_bad_config
        $error("fifo_packet_arbiter: PORT_COUNT, DATA_WIDTH and WATCHDOG_CYCLES must be >= 2");
    end

    arb_state_t             state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [DATA_WIDTH-1:0]  data_q,  data_d;
    logic                   valid_q, valid_d;

    logic [PORT_COUNT-1:0]  w_request;
    logic [GRANT_WIDTH-1:0] w_rr_grant;
    logic                   w_rr_found;
    logic [DATA_WIDTH-1:0]  w_granted_word;
    logic                   w_granted_valid;
    logic                   w_granted_empty;
    logic                   w_out_free;
    logic                   w_load;
    logic                   w_wdog_expired;

    assign w_request       = ~fifo_empty;
    assign w_granted_word  = fifo_read_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign w_granted_valid = fifo_read_data_valid[grant_q];
    assign w_granted_empty = fifo_empty[grant_q];
    // Output register can take a word if empty or draining this cycle
    assign w_out_free      = !valid_q || output_ready;

    round_robin_priority_encoder #(
        .PORT_COUNT  (PORT_COUNT),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_rr_encoder (
        .request        (w_request),
        .previous_grant (grant_q),
        .next_grant     (w_rr_grant),
        .found          (w_rr_found)
    );

`ifdef FIFO_PACKET_ARBITER_WATCHDOG_EN
    localparam int CNT_WIDTH = $clog2(WATCHDOG_CYCLES);

    logic [CNT_WIDTH-1:0] wdog_cnt_q, wdog_cnt_d;

    // Count WAIT cycles without a response; cleared in every other state
    always_comb begin
        wdog_cnt_d = '0;
        if (state_q == WAIT && !w_granted_valid) begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    assign w_wdog_expired = (state_q == WAIT) && !w_granted_valid &&
                            (wdog_cnt_q == CNT_WIDTH'(WATCHDOG_CYCLES - 1));
    assign watchdog_error = w_wdog_expired;
`else
    assign w_wdog_expired = 1'b0;
    assign watchdog_error = 1'b0;
`endif

    // Next-state, grant update and read strobe generation
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        fifo_read_enable = '0;
        w_load           = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_rr_found) begin
                    grant_d = w_rr_grant;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An empty granted FIFO mid-packet keeps the grant
                if (!w_granted_empty && w_out_free) begin
                    fifo_read_enable[grant_q] = 1'b1;
                    state_d                   = WAIT;
                end
            end
            WAIT: begin
                if (w_granted_valid) begin
                    w_load  = 1'b1;
                    state_d = w_granted_word[LAST_BIT] ? IDLE : ISSUE;
                end else if (w_wdog_expired) begin
                    // IDLE searches from grant_port+1, skipping the dead port
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers; grant resets to the last port so port 0 wins first
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= GRANT_WIDTH'(PORT_COUNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Egress holding register: load wins over drain so back-to-back words stay valid
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (w_load) begin
            data_d  = w_granted_word;
            valid_d = 1'b1;
        end else if (output_ready) begin
            valid_d = 1'b0;
        end
    end

    // Egress register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign output_data  = data_q;
    assign output_valid = valid_q;
    assign grant_port   = grant_q;
    assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_packet_arbiter
// Brief  : Self-checking bench for fifo_packet_arbiter. Queue-based FIFO
//          models feed the DUT; expected egress order is derived from the
//          preloaded packets by plain round-robin over ports with packets left.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_packet_arbiter;

    localparam int PN = 4;
    localparam int DW = 16;
    localparam int WD = 8;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b1;
    logic [PN-1:0]     fifo_empty;
    logic [PN*DW-1:0]  fifo_read_data;
    logic [PN-1:0]     fifo_read_data_valid;
    logic [PN-1:0]     fifo_read_enable;
    logic [DW-1:0]     output_data;
    logic              output_valid;
    logic              output_ready;
    logic [1:0]        grant_port;
    logic              busy;
    logic              watchdog_error;

    always #5 clock = ~clock;

    fifo_packet_arbiter #(
        .PORT_COUNT      (PN),
        .DATA_WIDTH      (DW),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .fifo_empty           (fifo_empty),
        .fifo_read_data       (fifo_read_data),
        .fifo_read_data_valid (fifo_read_data_valid),
        .fifo_read_enable     (fifo_read_enable),
        .output_data          (output_data),
        .output_valid         (output_valid),
        .output_ready         (output_ready),
        .grant_port           (grant_port),
        .busy                 (busy),
        .watchdog_error       (watchdog_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- FIFO / sink model state ----------------
    logic [DW-1:0] fq[PN][$];
    logic [DW-1:0] exp_words[$];
    int            rd_ports[$];
    int            serial;
    bit            pend_on;
    int            pend_cnt, pend_port, last_read;
    logic [DW-1:0] pend_word;
    int            hold[PN];
    int            pops[PN];
    int            stall_port, stall_after, stall_len, stall_cycles;
    bit            mute, junk_en, wd_allowed, rdy_stall_done;
    int            lat_mode, rdy_mode, rdy_low_left;
    bit            prev_ov, prev_rdy, prev_rd_any;
    logic [DW-1:0] prev_od;
    logic [PN-1:0] s_rd;
    bit            s_wd, s_bz;

    task automatic add_packet(input int p, input int len);
        for (int i = 0; i < len; i++) begin
            fq[p].push_back({(i == len - 1), 2'(p), 13'(serial)});
            serial++;
        end
    endtask

    // Expected order: round-robin over ports that still hold packets, starting after port PN-1
    task automatic build_expected();
        logic [DW-1:0] cq[PN][$];
        logic [DW-1:0] w;
        int prev, sel;
        for (int p = 0; p < PN; p++) cq[p] = fq[p];
        prev = PN - 1;
        forever begin
            sel = -1;
            for (int k = 1; k <= PN; k++)
                if (sel < 0 && cq[(prev + k) % PN].size() > 0) sel = (prev + k) % PN;
            if (sel < 0) break;
            do begin
                w = cq[sel].pop_front();
                exp_words.push_back(w);
                rd_ports.push_back(sel);
            end while (!w[DW-1]);
            prev = sel;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        fifo_empty = '1; fifo_read_data_valid = '0; fifo_read_data = '0; output_ready = 1'b1;
        for (int p = 0; p < PN; p++) begin fq[p].delete(); hold[p] = 0; pops[p] = 0; end
        exp_words.delete(); rd_ports.delete();
        pend_on = 0; pend_cnt = 0; pend_port = -1; last_read = -1;
        stall_port = -1; stall_after = 0; stall_len = 0; stall_cycles = 0;
        mute = 0; junk_en = 0; wd_allowed = 0; rdy_stall_done = 0;
        lat_mode = 1; rdy_mode = 0; rdy_low_left = 0;
        prev_ov = 0; prev_rdy = 1; prev_rd_any = 0; prev_od = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock cycle: drive inputs after negedge, sample/check, then advance the FIFO model
    task automatic cycle();
        logic [PN-1:0] rd;
        logic          ov;
        logic [DW-1:0] od, w;
        logic [1:0]    gp;
        for (int p = 0; p < PN; p++) begin
            fifo_empty[p] = (fq[p].size() == 0) || (hold[p] > 0);
            fifo_read_data[p*DW +: DW] = DW'($urandom);
        end
        fifo_read_data_valid = '0;
        if (junk_en)
            for (int p = 0; p < PN; p++)
                if (p != last_read) fifo_read_data_valid[p] = 1'($urandom_range(0, 1));
        if (pend_on && pend_cnt == 1 && !mute) begin
            fifo_read_data_valid[pend_port] = 1'b1;
            fifo_read_data[pend_port*DW +: DW] = pend_word;
        end
        case (rdy_mode)
            1: output_ready = ($urandom_range(0, 9) < 7);
            2: begin
                if (!rdy_stall_done && output_valid) begin rdy_low_left = 5; rdy_stall_done = 1; end
                output_ready = (rdy_low_left == 0);
                if (rdy_low_left > 0) rdy_low_left--;
            end
            default: output_ready = 1'b1;
        endcase
        #1;
        rd = fifo_read_enable; ov = output_valid; od = output_data; gp = grant_port;
        s_rd = rd; s_wd = watchdog_error; s_bz = busy;
        chk("rd_onehot", 64'($countones(rd) <= 1), 1);
        chk("rd_single_cycle", 64'((rd != 0) && prev_rd_any), 0);
        chk("rd_while_full", 64'((rd != 0) && ov && !output_ready), 0);
        if (prev_ov && !prev_rdy) begin
            chk("hold_valid", ov, 1);
            chk("hold_data", od, prev_od);
        end
        if (!wd_allowed) chk("wdog_quiet", watchdog_error, 0);
        if (stall_port >= 0 && hold[stall_port] > 0) begin
            stall_cycles++;
            chk("stall_no_read", rd, 0);
            chk("stall_grant", gp, stall_port);
        end
        if (rd != 0) begin
            if (rd_ports.size() == 0) fail("rd_unexpected");
            else begin
                chk("rd_port", rd, 64'(1) << rd_ports[0]);
                chk("grant_at_read", gp, rd_ports[0]);
                void'(rd_ports.pop_front());
            end
        end
        if (ov && output_ready) begin
            if (exp_words.size() == 0) fail("egress_extra");
            else begin
                w = exp_words.pop_front();
                chk("egress_word", od, w);
            end
        end
        prev_ov = ov; prev_rdy = output_ready; prev_od = od; prev_rd_any = (rd != 0);
        @(posedge clock);
        @(negedge clock);
        if (pend_on) begin
            if (pend_cnt == 1) pend_on = 0;
            else pend_cnt--;
        end
        for (int p = 0; p < PN; p++) if (hold[p] > 0) hold[p]--;
        for (int p = 0; p < PN; p++) begin
            if (rd[p]) begin
                if (fq[p].size() == 0) fail("read_of_empty_fifo");
                else begin
                    pend_word = fq[p].pop_front();
                    pend_on   = 1; pend_port = p; last_read = p;
                    pend_cnt  = (lat_mode == 0) ? int'($urandom_range(1, 2)) : lat_mode;
                    pops[p]++;
                    if (p == stall_port && pops[p] == stall_after) hold[p] = stall_len;
                end
            end
        end
    endtask

    task automatic run_model(input int budget);
        int n;
        build_expected();
        n = 0;
        while ((exp_words.size() > 0 || busy || output_valid) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) fail("run_timeout");
        chk("all_words_out", exp_words.size(), 0);
        chk("all_reads_done", rd_ports.size(), 0);
    endtask

    typedef struct {
        logic [3:0] empty;
        logic [1:0] grant;
        logic       busy;
        logic [3:0] rd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        fifo_empty = '1; fifo_read_data_valid = '0; fifo_read_data = '0; output_ready = 1'b1;
        serial = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", grant_port, 3);
        chk("rst_busy", busy, 0);
        chk("rst_valid", output_valid, 0);
        chk("rst_data", output_data, 0);
        chk("rst_rd", fifo_read_enable, 0);
        chk("rst_wdog", watchdog_error, 0);

        // First arbitration decision from reset, then the ISSUE strobe
        tbl[0] = '{4'b1111, 2'd3, 1'b0, 4'b0000};
        tbl[1] = '{4'b1110, 2'd0, 1'b1, 4'b0001};
        tbl[2] = '{4'b1101, 2'd1, 1'b1, 4'b0010};
        tbl[3] = '{4'b1011, 2'd2, 1'b1, 4'b0100};
        tbl[4] = '{4'b0111, 2'd3, 1'b1, 4'b1000};
        tbl[5] = '{4'b0000, 2'd0, 1'b1, 4'b0001};
        tbl[6] = '{4'b1001, 2'd1, 1'b1, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            do_reset();
            fifo_empty = tbl[i].empty;
            @(posedge clock);
            #1;
            chk("tbl_grant", grant_port, tbl[i].grant);
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_rd", fifo_read_enable, tbl[i].rd);
        end

        // Two 3-word packets on ports 0 and 2
        do_reset();
        add_packet(0, 3); add_packet(2, 3);
        run_model(200);

        // Single-word packets on every port, two rounds
        do_reset();
        for (int r = 0; r < 2; r++) for (int p = 0; p < PN; p++) add_packet(p, 1);
        run_model(300);

        // Port 1 FIFO runs dry after word 2 for 10 cycles
        do_reset();
        add_packet(1, 4); add_packet(2, 1);
        stall_port = 1; stall_after = 2; stall_len = 10;
        run_model(300);
        chk("stall_cycles", stall_cycles, 10);

        // Sink back-pressure for 5 cycles
        do_reset();
        add_packet(0, 4); add_packet(3, 2);
        rdy_mode = 2;
        run_model(300);
        chk("ready_stall_hit", rdy_stall_done, 1);

        // Lone port re-granted after its packet
        do_reset();
        add_packet(2, 2); add_packet(2, 3);
        lat_mode = 2;
        run_model(300);

        // Randomised traffic, latency, back-pressure and foreign valids
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int p = 0; p < PN; p++) begin
                int npk;
                npk = int'($urandom_range(0, 3));
                for (int k = 0; k < npk; k++) add_packet(p, int'($urandom_range(1, 5)));
            end
            lat_mode = 0; rdy_mode = 1; junk_en = 1;
            run_model(3000);
        end

        // Reset asserted in the middle of a packet
        do_reset();
        add_packet(0, 6);
        build_expected();
        for (int n = 0; n < 100 && exp_words.size() > 4; n++) cycle();
        chk("mid_two_words_out", exp_words.size(), 4);
        chk("mid_pre_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd", fifo_read_enable, 0);
        chk("mid_rst_valid", output_valid, 0);
        chk("mid_rst_data", output_data, 0);
        chk("mid_rst_grant", grant_port, 3);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wdog", watchdog_error, 0);
        @(posedge clock);
        #1;
        chk("mid_rst_no_read", fifo_read_enable, 0);

`ifdef FIFO_PACKET_ARBITER_WATCHDOG_EN
        // Port 3 never answers its read
        begin
            int rdc, wdc, nwd;
            do_reset();
            add_packet(3, 1);
            rd_ports.push_back(3);
            mute = 1; wd_allowed = 1;
            rdc = -1; wdc = -1; nwd = 0;
            for (int k = 0; k < 40; k++) begin
                cycle();
                if (s_rd != 0 && rdc < 0) rdc = k;
                if (wdc >= 0 && k == wdc + 1) chk("wdog_busy_after", s_bz, 0);
                if (s_wd) begin nwd++; if (wdc < 0) wdc = k; end
            end
            chk("wdog_delay", wdc - rdc, WD);
            chk("wdog_pulses", nwd, 1);
            chk("wdog_grant_kept", grant_port, 3);
            chk("wdog_idle", busy, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
